// File: rtl/lsu_mem_unit.sv
// Memory-stage load/store unit: turns execute-stage requests into word-aligned
// req/gnt/rvalid data-memory transactions and returns extended load data to write-back.
module lsu_mem_unit #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [2:0]  func3,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic        stall,
  output logic [31:0] load_data,
  output logic        load_valid,
  output logic        access_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RESP = 2'd2,
    S_DONE = 2'd3
  } state_e;

  localparam int unsigned CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TIMEOUT_L = CW'(TIMEOUT);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic          err_q;
  logic          we_q;
  logic [2:0]    f3_q;
  logic [1:0]    off_q;
  logic [31:0]   mem_addr_q, mem_wdata_q, load_data_q;
  logic [3:0]    mem_wstrb_q;

  logic          op_legal, op_misal;
  logic [3:0]    wstrb_new;
  logic [31:0]   wdata_new;
  logic [31:0]   rd_shift, rd_ext;
  logic          accept, capture, timeout_hit;

  // Request decode: width/sign legality and natural alignment.
  always_comb begin
    op_legal = 1'b0;
    case (func3)
      3'b000, 3'b001, 3'b010: op_legal = 1'b1;
      3'b100, 3'b101:         op_legal = ~req_we;
      default:                op_legal = 1'b0;
    endcase
    op_misal = ((func3[1:0] == 2'b01) && addr[0]) ||
               ((func3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
  end

  always_comb begin
    wstrb_new = 4'b0000;
    wdata_new = 32'h0;
    if (req_we) begin
      case (func3[1:0])
        2'b00: begin
          wstrb_new = 4'b0001 << addr[1:0];
          wdata_new = {4{store_data[7:0]}};
        end
        2'b01: begin
          wstrb_new = 4'b0011 << addr[1:0];
          wdata_new = {2{store_data[15:0]}};
        end
        default: begin
          wstrb_new = 4'b1111;
          wdata_new = store_data;
        end
      endcase
    end
  end

  // Load lane extraction uses the offset and width latched at request time.
  always_comb begin
    rd_shift = mem_rdata >> {off_q, 3'b000};
    case (f3_q)
      3'b000:  rd_ext = {{24{rd_shift[7]}}, rd_shift[7:0]};
      3'b001:  rd_ext = {{16{rd_shift[15]}}, rd_shift[15:0]};
      3'b100:  rd_ext = {24'h0, rd_shift[7:0]};
      3'b101:  rd_ext = {16'h0, rd_shift[15:0]};
      default: rd_ext = rd_shift;
    endcase
  end

  // Handshake: mem_req stays high through REQ; the request is taken in a cycle
  // with mem_gnt=1. Read data is accepted in any REQ/RESP cycle where the grant
  // has happened (same cycle or later) and mem_rvalid=1; rvalid elsewhere is ignored.
  assign cnt_inc = cnt_q + 1'b1;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    stall       = 1'b0;
    mem_req     = 1'b0;
    load_valid  = 1'b0;
    access_err  = 1'b0;
    accept      = 1'b0;
    capture     = 1'b0;
    timeout_hit = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          if (!op_legal || op_misal) begin
            access_err = 1'b1;
          end else begin
            stall   = 1'b1;
            accept  = 1'b1;
            cnt_d   = '0;
            state_d = S_REQ;
          end
        end
      end
      S_REQ: begin
        mem_req = 1'b1;
        stall   = 1'b1;
        cnt_d   = cnt_inc;
        if (mem_gnt && we_q) begin
          state_d = S_DONE;
        end else if (mem_gnt && mem_rvalid) begin
          capture = 1'b1;
          state_d = S_DONE;
        end else if (cnt_inc == TIMEOUT_L) begin
          timeout_hit = 1'b1;
          state_d     = S_DONE;
        end else if (mem_gnt) begin
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        stall = 1'b1;
        cnt_d = cnt_inc;
        if (mem_rvalid) begin
          capture = 1'b1;
          state_d = S_DONE;
        end else if (cnt_inc == TIMEOUT_L) begin
          timeout_hit = 1'b1;
          state_d     = S_DONE;
        end
      end
      S_DONE: begin
        load_valid = ~we_q & ~err_q;
        access_err = err_q;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      we_q        <= 1'b0;
      f3_q        <= 3'b000;
      off_q       <= 2'b00;
      mem_addr_q  <= 32'h0;
      mem_wdata_q <= 32'h0;
      mem_wstrb_q <= 4'b0000;
      load_data_q <= 32'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        err_q       <= 1'b0;
        we_q        <= req_we;
        f3_q        <= func3;
        off_q       <= addr[1:0];
        mem_addr_q  <= {addr[31:2], 2'b00};
        mem_wdata_q <= wdata_new;
        mem_wstrb_q <= wstrb_new;
      end
      if (capture) begin
        load_data_q <= rd_ext;
      end
      if (timeout_hit) begin
        err_q       <= 1'b1;
        load_data_q <= 32'h0;
      end
    end
  end

  assign mem_we    = we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_wstrb = mem_wstrb_q;
  assign load_data = load_data_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_lsu_mem_unit.sv
// Bench for lsu_mem_unit: directed and random load/store traffic against a
// reference lane model, with load/error results checked through an expected queue.
module tb_lsu_mem_unit;

  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [2:0]  func3 = 3'b000;
  logic [31:0] addr = 32'h0;
  logic [31:0] store_data = 32'h0;
  logic        stall;
  logic [31:0] load_data;
  logic        load_valid;
  logic        access_err;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_gnt = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = 32'h0;
  logic [1:0]  dbg_state;

  int chk_cnt = 0;
  int pass_cnt = 0;
  logic [33:0] exp_q[$];

  lsu_mem_unit #(.TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_we     (req_we),
    .func3      (func3),
    .addr       (addr),
    .store_data (store_data),
    .stall      (stall),
    .load_data  (load_data),
    .load_valid (load_valid),
    .access_err (access_err),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_wstrb  (mem_wstrb),
    .mem_gnt    (mem_gnt),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .dbg_state  (dbg_state)
  );

  always #5 clk = ~clk;

  // Result monitor: every load_valid/access_err pulse must match the queue head.
  always begin : monitor
    logic [33:0] obs;
    logic [33:0] exp;
    @(negedge clk);
    #2;
    if (rst_n && (load_valid || access_err)) begin
      obs = {access_err, load_valid, (load_valid ? load_data : 32'h0)};
      chk_cnt++;
      if (exp_q.size() == 0) begin
        $display("FAIL sb_unexpected got=%h expected=none", obs);
      end else begin
        exp = exp_q.pop_front();
        if (obs !== exp) $display("FAIL sb_result got=%h expected=%h", obs, exp);
        else pass_cnt++;
      end
    end
  end

  function automatic logic m_bad(input logic we, input logic [2:0] f3, input logic [31:0] a);
    logic legal;
    legal = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010) ||
            (!we && ((f3 == 3'b100) || (f3 == 3'b101)));
    if (!legal) return 1'b1;
    if ((f3 == 3'b001 || f3 == 3'b101) && a[0]) return 1'b1;
    if (f3 == 3'b010 && a[1:0] != 2'b00) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [3:0] m_strb(input logic we, input logic [2:0] f3, input logic [1:0] off);
    if (!we) return 4'b0000;
    case (f3)
      3'b000: case (off)
        2'd0: return 4'b0001;
        2'd1: return 4'b0010;
        2'd2: return 4'b0100;
        default: return 4'b1000;
      endcase
      3'b001: return (off == 2'd0) ? 4'b0011 : 4'b1100;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] sd);
    case (f3)
      3'b000:  return {sd[7:0], sd[7:0], sd[7:0], sd[7:0]};
      3'b001:  return {sd[15:0], sd[15:0]};
      default: return sd;
    endcase
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [1:0] off, input logic [31:0] rd);
    int o;
    logic [7:0]  b;
    logic [15:0] h;
    o = int'(off) * 8;
    b = rd[o +: 8];
    h = (off == 2'd0) ? rd[15:0] : rd[31:16];
    case (f3)
      3'b000:  return b[7] ? {24'hFFFFFF, b} : {24'h0, b};
      3'b100:  return {24'h0, b};
      3'b001:  return h[15] ? {16'hFFFF, h} : {16'h0, h};
      3'b101:  return {16'h0, h};
      default: return rd;
    endcase
  endfunction

  // One complete operation; gnt_dly = REQ cycles before grant, rv_dly = cycles
  // after grant until rvalid (0 = same cycle, negative = never).
  task automatic do_op(input string name, input logic we, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] sd,
                       input int gnt_dly, input int rv_dly, input logic [31:0] rdata);
    int    stalls, req_cyc, since_gnt, es;
    bit    granted, done, bad;
    logic [68:0] got_m, exp_m;
    stalls = 0; req_cyc = 0; since_gnt = 0; granted = 0; done = 0;
    bad = m_bad(we, f3, a);
    if (bad) es = 0;
    else if (we) es = 2 + gnt_dly;
    else if (rv_dly < 0) es = 1 + TIMEOUT;
    else es = 2 + gnt_dly + rv_dly;
    if (bad || (!we && rv_dly < 0)) exp_q.push_back({2'b10, 32'h0});
    else if (!we) exp_q.push_back({2'b01, m_load(f3, a[1:0], rdata)});
    exp_m = {{a[31:2], 2'b00}, we, m_strb(we, f3, a[1:0]), (we ? m_wdata(f3, sd) : 32'h0)};
    @(negedge clk);
    req_valid = 1'b1; req_we = we; func3 = f3; addr = a; store_data = sd;
    mem_gnt = 1'b0; mem_rvalid = 1'b0;
    for (int c = 0; c < 60 && !done; c++) begin
      #1;
      if (!stall) begin
        done = 1;
      end else begin
        stalls++;
        mem_gnt = 1'b0;
        mem_rvalid = 1'b0;
        if (mem_req) begin
          got_m = {mem_addr, mem_we, mem_wstrb, (we ? mem_wdata : 32'h0)};
          chk_cnt++;
          if (got_m !== exp_m) $display("FAIL %s_memif got=%h expected=%h", name, got_m, exp_m);
          else pass_cnt++;
          if (req_cyc == gnt_dly) begin
            mem_gnt = 1'b1;
            granted = 1;
            if (!we && rv_dly == 0) begin
              mem_rvalid = 1'b1;
              mem_rdata = rdata;
            end
          end
          req_cyc++;
        end else if (granted && !we) begin
          since_gnt++;
          if (since_gnt == rv_dly) begin
            mem_rvalid = 1'b1;
            mem_rdata = rdata;
          end
        end
        @(negedge clk);
      end
    end
    mem_gnt = 1'b0;
    mem_rvalid = 1'b0;
    chk_cnt++;
    if (!done) $display("FAIL %s_complete got=stuck expected=release_within_60", name);
    else if (stalls != es) $display("FAIL %s_stall got=%0d expected=%0d", name, stalls, es);
    else pass_cnt++;
    @(negedge clk);
    req_valid = 1'b0;
    #1;
    if (bad) begin
      chk_cnt++;
      if ({req_cyc, mem_req, dbg_state} !== {32'd0, 1'b0, 2'd0})
        $display("FAIL %s_noreq got=%0d/%b/%0d expected=0/0/0", name, req_cyc, mem_req, dbg_state);
      else pass_cnt++;
    end
  endtask

  task automatic test_reset();
    #12;
    chk_cnt++;
    if ({stall, mem_req, mem_we, load_valid, access_err, mem_addr, mem_wdata, mem_wstrb, load_data, dbg_state} !== '0)
      $display("FAIL reset_outputs got=%b/%b/%h/%h/%h expected=all_zero", stall, mem_req, mem_addr, mem_wdata, load_data);
    else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_store();
    do_op("sw", 1'b1, 3'b010, 32'h0000_0100, 32'hDEAD_BEEF, 0, 0, 32'h0);
    do_op("sb", 1'b1, 3'b000, 32'h0000_0103, 32'h0000_00A5, 0, 0, 32'h0);
    do_op("sh", 1'b1, 3'b001, 32'h0000_0102, 32'h1234_5678, 1, 0, 32'h0);
  endtask

  task automatic test_load();
    do_op("lb",  1'b0, 3'b000, 32'h0000_0202, 32'h0, 0, 1, 32'h1280_FF34);
    do_op("lbu", 1'b0, 3'b100, 32'h0000_0202, 32'h0, 0, 1, 32'h1280_FF34);
    do_op("lh",  1'b0, 3'b001, 32'h0000_0200, 32'h0, 0, 2, 32'h1280_FF34);
    do_op("lhu", 1'b0, 3'b101, 32'h0000_0200, 32'h0, 2, 1, 32'h1280_FF34);
    do_op("lw0", 1'b0, 3'b010, 32'h0000_0204, 32'h0, 1, 0, 32'h8765_4321);
    chk_cnt++;
    if (load_data !== 32'h8765_4321) $display("FAIL load_hold got=%h expected=87654321", load_data);
    else pass_cnt++;
  endtask

  task automatic test_errors();
    do_op("lh_mis",  1'b0, 3'b001, 32'h0000_0201, 32'h0, 0, 1, 32'h0);
    do_op("ld_ill",  1'b0, 3'b011, 32'h0000_0200, 32'h0, 0, 1, 32'h0);
    do_op("sw_mis",  1'b1, 3'b010, 32'h0000_0102, 32'h1, 0, 0, 32'h0);
    do_op("st_ill",  1'b1, 3'b100, 32'h0000_0100, 32'h1, 0, 0, 32'h0);
  endtask

  task automatic test_timeout();
    do_op("timeout", 1'b0, 3'b010, 32'h0000_0208, 32'h0, 3, -1, 32'h0);
    chk_cnt++;
    if ({load_data, dbg_state} !== {32'h0, 2'd0}) $display("FAIL timeout_state got=%h/%0d expected=0/0", load_data, dbg_state);
    else pass_cnt++;
  endtask

  task automatic test_stray_rvalid();
    logic [31:0] held;
    held = load_data;
    @(negedge clk);
    mem_rvalid = 1'b1;
    mem_rdata = 32'h5555_AAAA;
    @(negedge clk);
    mem_rvalid = 1'b0;
    #1;
    chk_cnt++;
    if ({load_data, dbg_state, stall} !== {held, 2'd0, 1'b0}) $display("FAIL stray_rvalid got=%h/%0d expected=%h/0", load_data, dbg_state, held);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_resp();
    int w;
    do_op("lbu_pre", 1'b0, 3'b100, 32'h0000_0202, 32'h0, 0, 1, 32'h1280_FF34);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; func3 = 3'b010; addr = 32'h0000_0300;
    w = 0;
    #1;
    while (!mem_req && w < 5) begin
      @(negedge clk);
      #1;
      w++;
    end
    mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    #1;
    chk_cnt++;
    if ({dbg_state, stall} !== {2'd2, 1'b1}) $display("FAIL rst_pre_resp got=%0d/%b expected=2/1", dbg_state, stall);
    else pass_cnt++;
    #1;
    rst_n = 1'b0;
    req_valid = 1'b0;
    #1;
    chk_cnt++;
    if ({stall, mem_req, mem_we, load_valid, access_err, mem_addr, mem_wdata, mem_wstrb, load_data, dbg_state} !== '0)
      $display("FAIL rst_mid_resp got=%b/%b/%h/%h/%0d expected=all_zero", stall, mem_req, mem_addr, load_data, dbg_state);
    else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    do_op("lw_post", 1'b0, 3'b010, 32'h0000_0040, 32'h0, 0, 1, 32'hCAFE_F00D);
    chk_cnt++;
    if (load_data !== 32'hCAFE_F00D) $display("FAIL post_reset_lw got=%h expected=cafef00d", load_data);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [2:0] f3_tab[8];
    logic       we;
    logic [2:0] f3;
    f3_tab = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b010, 3'b000, 3'b110};
    for (int i = 0; i < 24; i++) begin
      we = 1'($urandom_range(0, 1));
      f3 = f3_tab[$urandom_range(0, 7)];
      do_op("rand", we, f3, {$urandom_range(0, 32'h3FFF), 2'($urandom_range(0, 3))},
            $urandom, int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), $urandom);
    end
  endtask

  initial begin
    test_reset();
    test_store();
    test_load();
    test_errors();
    test_timeout();
    test_stray_rvalid();
    test_reset_mid_resp();
    test_back_to_back();
    repeat (3) @(negedge clk);
    chk_cnt++;
    if (exp_q.size() != 0) $display("FAIL sb_drain got=%0d expected=0", exp_q.size());
    else pass_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/lsu_mem_unit.md
Name: lsu_mem_unit

Overview:
- Load/store unit in the memory stage, directly upstream of the write-back select mux.
- Converts execute-stage load/store requests into word-aligned data-memory transactions over a req/gnt/rvalid handshake.
- Stalls the pipeline while a transaction is outstanding.
- Delivers byte/half/word-extracted, sign/zero-extended load data as the write-back "memory read" operand (wb_sel = 2'b10).

Parameters:
- TIMEOUT, 16: maximum cycles spent in REQ+RESP before the access is aborted with an error (≥2).

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  memory op present in stage; held stable while stall=1
- req_we  in  1  1=store, 0=load
- func3  in  3  RV32I width/sign code
- addr  in  32  byte address (ALU result)
- store_data  in  32  rs2 value
- stall  out  1  freeze upstream pipeline
- load_data  out  32  extended load result to write-back mux
- load_valid  out  1  load_data valid (one-cycle pulse)
- access_err  out  1  misaligned/illegal/timeout (one-cycle pulse)
- mem_req  out  1  memory request
- mem_we  out  1  memory write enable
- mem_addr  out  32  word address, {addr[31:2],2'b00}
- mem_wdata  out  32  lane-replicated store data
- mem_wstrb  out  4  byte strobes
- mem_gnt  in  1  request accepted this cycle
- mem_rvalid  in  1  read data valid
- mem_rdata  in  32  read word

Behaviour:
- Reset (async, immediate, including mid-transaction): state=IDLE; mem_req, mem_we, load_valid, access_err = 0; mem_addr, mem_wdata, load_data = 0; mem_wstrb = 0; timeout counter = 0.
- Legal func3:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
  - All other codes are illegal.
- Misaligned: halfword with addr[0]=1; word with addr[1:0]≠00.
- State IDLE:
  - req_valid & (illegal|misaligned): no memory request, access_err=1 for one cycle, stall=0, next state IDLE.
  - req_valid & legal: stall=1 combinationally; register mem_addr/mem_we/mem_wdata/mem_wstrb, next state REQ.
- State REQ:
  - mem_req=1, stall=1, counter increments each cycle.
  - mem_gnt & store: next DONE.
  - mem_gnt & load & mem_rvalid in the same cycle: capture data, next DONE.
  - mem_gnt & load otherwise: next RESP.
- State RESP:
  - mem_req=0, stall=1.
  - mem_rvalid: capture extended data into load_data, next DONE.
  - mem_rvalid asserted outside REQ/RESP is ignored.
- Timeout: counter reaching TIMEOUT in REQ or RESP forces DONE with access_err=1 and load_data=0. Counter clears on entry to REQ.
- State DONE:
  - stall=0; load_valid=1 for loads (no error); next IDLE unconditionally.
  - The still-asserted req_valid of the completing op is ignored.
  - Minimum latency: store 2 cycles of stall (IDLE, REQ with gnt); load with rvalid one cycle after gnt: 3.
- Store lanes (off=addr[1:0]):
  - SB: wstrb=4'b0001<<off, wdata={4{sd[7:0]}}.
  - SH: wstrb=4'b0011<<off, wdata={2{sd[15:0]}}.
  - SW: wstrb=4'b1111, wdata=sd.
  - Loads drive wstrb=0, mem_we=0.
- Load extraction: sh = mem_rdata >> (8*off).
  - LB/LBU: sign/zero-extend sh[7:0].
  - LH/LHU: sign/zero-extend sh[15:0].
  - LW: full word.
- load_data holds its value until the next load capture or reset.
- Memory outputs hold stable from REQ entry until return to IDLE.

Test Plan:
- SW addr=0x100, sd=0xDEADBEEF, gnt on first REQ cycle -> mem_addr=0x100, wstrb=1111, wdata=0xDEADBEEF, mem_we=1; stall high 2 cycles; no load_valid.
- SB addr=0x103, sd=0x000000A5 -> wstrb=1000, wdata=0xA5A5A5A5, mem_addr=0x100.
- LB then LBU at addr=0x202, mem_rdata=0x1280FF34 (rvalid one cycle after gnt) -> load_data=0xFFFFFF80 then 0x00000080; load_valid pulses in DONE; stall 3 cycles each.
- LH addr=0x201 -> access_err one-cycle pulse, mem_req never asserted, stall=0. func3=011 load -> same response.
- Load with gnt after 3 cycles, rvalid never returned, TIMEOUT=16 -> access_err in DONE, load_data=0x0, stall released, FSM back to IDLE.
- rst_n low while in RESP -> mem_req/stall/outputs 0 immediately. Post-reset LW at 0x40, rdata=0xCAFEF00D -> load_data=0xCAFEF00D.
